ram_loader: RTL
===============

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL have exactly one parameter: WORDS, default 16, number of RAM words loaded per program image (4-bit address space, fixed at 16).
REQ-002 The block SHALL provide these ports, one per line below.
REQ-003 CLK  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 RESETn  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  request to begin loading a program image.
REQ-006 ABORT  input  1  cancels an in-progress load.
REQ-007 BYTE_IN  input  8  incoming program byte.
REQ-008 BYTE_VALID  input  1  BYTE_IN is valid this cycle.
REQ-009 BYTE_READY  output  1  the loader accepts a byte this cycle.
REQ-010 LOAD_ADDR  output  4  RAM address; connects to the RAM ADDR input.
REQ-011 LOAD_DATA  output  8  RAM write data; connects to the RAM DIN input.
REQ-012 LOAD_RI  output  1  RAM write enable; connects to the RAM RI input.
REQ-013 BUSY  output  1  load in progress; holds the CPU off the RAM bus.
REQ-014 DONE  output  1  a full image has been written.
REQ-015 CHECKSUM  output  8  modulo-256 sum of the bytes written in the current or last load.

Function
REQ-016 The block SHALL implement a four-state machine: IDLE, RECV, WRITE, FINISHED.
REQ-017 IDLE: BYTE_READY=0, BUSY=0, DONE=0; START=1 -> RECV, with address counter=0 and CHECKSUM=0.
REQ-018 RECV: BYTE_READY=1, BUSY=1; a byte SHALL be accepted only on a cycle with BYTE_VALID=1 and BYTE_READY=1.
REQ-019 On acceptance, the block SHALL capture BYTE_IN into a data register and go to WRITE on the next edge.
REQ-020 WRITE SHALL last exactly one cycle with LOAD_RI=1, LOAD_ADDR=counter, LOAD_DATA=captured byte, BYTE_READY=0, and BUSY=1.
REQ-021 At the end of WRITE, CHECKSUM SHALL become CHECKSUM+byte, with the carry discarded.
REQ-022 From WRITE: if counter==WORDS-1 -> FINISHED with the counter unchanged; otherwise counter+1 -> RECV.
REQ-023 FINISHED: DONE=1, BUSY=0, BYTE_READY=0; CHECKSUM SHALL hold; START=1 -> RECV with counter=0, CHECKSUM=0, DONE=0.
REQ-024 Maximum throughput SHALL be one byte per two cycles.
REQ-025 BYTE_VALID while BYTE_READY=0 SHALL be ignored; no byte is consumed or written.
REQ-026 Outside WRITE, LOAD_RI SHALL be 0, LOAD_ADDR SHALL equal the counter, and LOAD_DATA SHALL equal the data register.
REQ-027 START in RECV or WRITE SHALL be ignored.
REQ-028 ABORT in RECV or WRITE -> IDLE on the next edge, with CHECKSUM held and DONE=0.
REQ-029 ABORT in WRITE SHALL force LOAD_RI=0 in that cycle, so no RAM write occurs.
REQ-030 ABORT and START in the same cycle SHALL be resolved in favour of ABORT.
REQ-031 ABORT in IDLE or FINISHED SHALL have no effect.
REQ-032 Counter wrap-around SHALL NOT occur; the counter never exceeds WORDS-1.
REQ-033 LOAD_RI SHALL be driven directly from registered state and ABORT only, glitch-free with respect to BYTE_IN.

Reset
REQ-034 RESETn=0 SHALL immediately, without waiting for a clock, force state=IDLE, counter=0, data register=0, and CHECKSUM=0.
REQ-035 Consequently, during reset LOAD_RI=0, BYTE_READY=0, BUSY=0, DONE=0, LOAD_ADDR=0, and LOAD_DATA=0.
REQ-036 Reset asserted mid-load SHALL abandon the load; a write in progress that cycle SHALL be suppressed, since LOAD_RI drops asynchronously.
REQ-037 Leaving reset SHALL require an explicit START before any byte is accepted.

Verification
REQ-038 Full load: START, then bytes 0x01..0x10 with BYTE_VALID held high -> 16 LOAD_RI pulses at addresses 0..15 with matching data; DONE=1; CHECKSUM=0x88; RAM readback matches.
REQ-039 Throttled source: BYTE_VALID asserted every 5th cycle -> identical RAM contents; LOAD_RI never asserted without a preceding accepted byte.
REQ-040 Abort: ABORT in the cycle WRITE is active for address 5 -> no write at address 5, IDLE next cycle, BUSY=0, DONE=0; addresses 0-4 written.
REQ-041 Async reset: RESETn pulled low mid-cycle during WRITE -> LOAD_RI falls before the next CLK edge; all outputs are 0 after release.
REQ-042 Reload: START in FINISHED -> DONE clears, CHECKSUM=0, and the next byte goes to address 0; START during RECV is ignored, with counter unchanged.
REQ-043 Simultaneous events: START+ABORT in IDLE -> no state change, BUSY=0, RAM untouched.

Source files
------------

// File: rtl/ram_loader.sv
// Program-image loader: accepts a byte stream and writes it into a 16-word RAM,
// one byte per write cycle. It keeps a running modulo-256 checksum of the
// bytes written.
module ram_loader #(
  parameter int WORDS = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic       BYTE_READY,
  output logic [3:0] LOAD_ADDR,
  output logic [7:0] LOAD_DATA,
  output logic       LOAD_RI,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] CHECKSUM
);

  localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    FINISHED
  } state_t;

  state_t     state, state_next;
  logic [3:0] count, count_next;
  logic [7:0] data, data_next;
  logic [7:0] sum, sum_next;

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      count <= '0;
      data  <= '0;
      sum   <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      data  <= data_next;
      sum   <= sum_next;
    end
  end

  // Next-state and datapath update; ABORT takes priority over START and bytes
  always_comb begin
    state_next = state;
    count_next = count;
    data_next  = data;
    sum_next   = sum;
    unique case (state)
      IDLE, FINISHED: begin
        if (START && !ABORT) begin
          state_next = RECV;
          count_next = '0;
          sum_next   = '0;
        end
      end
      RECV: begin
        if (ABORT) begin
          state_next = IDLE;
        end else if (BYTE_VALID) begin
          data_next  = BYTE_IN;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (ABORT) begin
          state_next = IDLE;
        end else begin
          sum_next = sum + data;
          if (count == LAST_ADDR) begin
            state_next = FINISHED;
          end else begin
            count_next = count + 4'd1;
            state_next = RECV;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state; LOAD_RI depends only on state and ABORT
  always_comb begin
    BYTE_READY = (state == RECV);
    BUSY       = (state == RECV) || (state == WRITE);
    DONE       = (state == FINISHED);
    LOAD_RI    = (state == WRITE) && !ABORT;
    LOAD_ADDR  = count;
    LOAD_DATA  = data;
    CHECKSUM   = sum;
  end

endmodule
